// File: rtl/accfifo_pkg.sv
// Shared types and helpers for the ping-pong accumulation FIFO.
// The saturating adder is only used when ACCFIFO_SATURATE_EN is defined.
package accfifo_pkg;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_ACC    = 2'd1,
    OP_ZERO   = 2'd2,
    OP_RECIRC = 2'd3
  } op_e;

  localparam int OP_WIDTH       = 2;
  localparam int SAT_CALC_WIDTH = 64;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Operands arrive sign-extended; the result is clamped to a w-bit signed range.
  function automatic logic signed [SAT_CALC_WIDTH-1:0] sat_add(
    input  logic signed [SAT_CALC_WIDTH-1:0] a,
    input  logic signed [SAT_CALC_WIDTH-1:0] b,
    input  int                               w,
    output logic                             clamped
  );
    logic signed [SAT_CALC_WIDTH-1:0] sum;
    logic signed [SAT_CALC_WIDTH-1:0] hi;
    logic signed [SAT_CALC_WIDTH-1:0] lo;
    sum     = a + b;
    hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (w - 1));
    clamped = 1'b0;
    if (sum > hi) begin
      sum     = hi;
      clamped = 1'b1;
    end else if (sum < lo) begin
      sum     = lo;
      clamped = 1'b1;
    end
    return sum;
  endfunction

endpackage

// File: rtl/accfifo_bank.sv
// First-word fall-through synchronous FIFO bank; head is read combinationally.
// A pop and push together on a full bank is accepted and leaves the count unchanged.
module accfifo_bank
  import accfifo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 24,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pingpong_accfifo_v2.sv
// Double-buffered accumulation FIFO: compute bank takes ops, shadow bank drains.
// Optional saturation on ACC is enabled by defining ACCFIFO_SATURATE_EN.
module pingpong_accfifo_v2
  import accfifo_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = $clog2(NB_DATA + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic [1:0]            op_code,
  input  logic [DATA_WIDTH-1:0] psum_in,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  compute_count,
  output logic [CNT_WIDTH-1:0]  shadow_count,
  output logic                  which_bank,
  output logic                  ovf_err,
  output logic                  udf_err,
  output logic                  sat_flag
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic                  which_reg;
  logic [0:0]            state_reg;
  logic [0:0]            state_next;
  logic                  swap_ack_reg;
  logic                  ovf_reg;
  logic                  udf_reg;

  logic [DATA_WIDTH-1:0] bank_head [2];
  logic [CNT_WIDTH-1:0]  bank_count [2];
  logic [1:0]            bank_empty;
  logic [1:0]            bank_full;
  logic [1:0]            bank_push;
  logic [1:0]            bank_pop;

  op_e                   op;
  logic                  c_push;
  logic                  c_pop;
  logic                  d_pop;
  logic                  fire;
  logic                  ovf_set;
  logic                  udf_set;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [DATA_WIDTH-1:0] c_head;
  logic [DATA_WIDTH-1:0] acc_sum;
  logic                  c_empty;
  logic                  c_full;

  assign op            = op_e'(op_code);
  assign c_head        = bank_head[which_reg];
  assign c_empty       = bank_empty[which_reg];
  assign c_full        = bank_full[which_reg];
  assign compute_count = bank_count[which_reg];
  assign shadow_count  = bank_count[!which_reg];
  assign out_data      = bank_head[!which_reg];
  assign out_valid     = (shadow_count != '0);
  assign d_pop         = out_valid && out_ready;
  assign which_bank    = which_reg;
  assign swap_ack      = swap_ack_reg;
  assign ovf_err       = ovf_reg;
  assign udf_err       = udf_reg;

  always_comb begin
    c_push  = 1'b0;
    c_pop   = 1'b0;
    c_wdata = psum_in;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (op_valid) begin
      case (op)
        OP_INIT, OP_ZERO: begin
          if (c_full) ovf_set = 1'b1;
          else        c_push  = 1'b1;
          if (op == OP_ZERO) c_wdata = '0;
        end
        OP_ACC, OP_RECIRC: begin
          if (c_empty) begin
            udf_set = 1'b1;
          end else begin
            c_pop   = 1'b1;
            c_push  = 1'b1;
            c_wdata = (op == OP_ACC) ? acc_sum : c_head;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ACCFIFO_SATURATE_EN
  logic signed [SAT_CALC_WIDTH-1:0] ext_head;
  logic signed [SAT_CALC_WIDTH-1:0] ext_psum;
  logic                             sat_clamped;
  logic                             sat_reg;

  assign ext_head = SAT_CALC_WIDTH'($signed(c_head));
  assign ext_psum = SAT_CALC_WIDTH'($signed(psum_in));

  always_comb begin
    acc_sum = DATA_WIDTH'(sat_add(ext_head, ext_psum, DATA_WIDTH, sat_clamped));
  end

  // Only a clamp on an ACC that actually executed raises the flag.
  always_ff @(posedge clk) begin
    if (rst) sat_reg <= 1'b0;
    else if (op_valid && op == OP_ACC && !c_empty && sat_clamped) sat_reg <= 1'b1;
  end

  assign sat_flag = sat_reg;
`else
  assign acc_sum  = c_head + psum_in;
  assign sat_flag = 1'b0;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_push[gi] = c_push && (which_reg == 1'(gi));
    assign bank_pop[gi]  = (which_reg == 1'(gi)) ? c_pop : d_pop;

    accfifo_bank #(
      .DEPTH (NB_DATA),
      .WIDTH (DATA_WIDTH),
      .CNT_W (CNT_WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .push  (bank_push[gi]),
      .pop   (bank_pop[gi]),
      .wdata (c_wdata),
      .head  (bank_head[gi]),
      .count (bank_count[gi]),
      .empty (bank_empty[gi]),
      .full  (bank_full[gi])
    );
  end

  // A request arriving on the firing edge re-arms the pending state.
  always_comb begin
    fire       = (state_reg == ST_PENDING) && (shadow_count == '0) && !op_valid;
    state_next = state_reg;
    if (swap_req)  state_next = ST_PENDING;
    else if (fire) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      which_reg    <= 1'b0;
      state_reg    <= ST_IDLE;
      swap_ack_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      udf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      swap_ack_reg <= fire;
      if (fire) which_reg <= ~which_reg;
      if (ovf_set) ovf_reg <= 1'b1;
      if (udf_set) udf_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pingpong_accfifo_v2.sv
// Bench for pingpong_accfifo_v2 (NB_DATA=4): vector table, directed corners, random vs queue model.
// Expectations adapt to ACCFIFO_SATURATE_EN.
module tb_pingpong_accfifo_v2;

  localparam int     NB   = 4;
  localparam int     W    = 24;
  localparam int     CW   = $clog2(NB + 1);
  localparam longint MAXV = 2 ** (W - 1) - 1;
  localparam longint MINV = -(2 ** (W - 1));

  localparam logic [1:0] C_INIT = 2'd0;
  localparam logic [1:0] C_ACC  = 2'd1;
  localparam logic [1:0] C_ZERO = 2'd2;
  localparam logic [1:0] C_REC  = 2'd3;

  logic          clk;
  logic          rst;
  logic          op_valid;
  logic [1:0]    op_code;
  logic [W-1:0]  psum_in;
  logic          swap_req;
  logic          swap_ack;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] compute_count;
  logic [CW-1:0] shadow_count;
  logic          which_bank;
  logic          ovf_err;
  logic          udf_err;
  logic          sat_flag;

  pingpong_accfifo_v2 #(
    .NB_DATA    (NB),
    .DATA_WIDTH (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .op_code       (op_code),
    .psum_in       (psum_in),
    .swap_req      (swap_req),
    .swap_ack      (swap_ack),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .compute_count (compute_count),
    .shadow_count  (shadow_count),
    .which_bank    (which_bank),
    .ovf_err       (ovf_err),
    .udf_err       (udf_err),
    .sat_flag      (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue per bank plus role/flag bits.
  logic [W-1:0] mq [2][$];
  int           m_wb;
  bit           m_pend, m_ack, m_ovf, m_udf, m_sat;

  typedef struct {
    logic         v;
    logic [1:0]   code;
    logic [W-1:0] p;
    logic         sr;
    logic         ordy;
    int           cc;
    int           sc;
    logic         wb;
    logic         ack;
    logic         ov;
    logic [W-1:0] data;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(input logic v, input logic [1:0] code, input logic [W-1:0] p,
                              input logic sr, input logic ordy, input int cc, input int sc,
                              input logic wb, input logic ack, input logic ov,
                              input logic [W-1:0] data);
    vec_t t;
    t.v = v; t.code = code; t.p = p; t.sr = sr; t.ordy = ordy;
    t.cc = cc; t.sc = sc; t.wb = wb; t.ack = ack; t.ov = ov; t.data = data;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [1:0] code,
                            input logic [W-1:0] p, input logic sr, input logic ordy);
    int           c;
    int           s;
    bit           fire;
    logic [W-1:0] h;
    logic [W-1:0] nv;
    longint       sm;
    if (r) begin
      mq[0].delete();
      mq[1].delete();
      m_wb = 0; m_pend = 0; m_ack = 0; m_ovf = 0; m_udf = 0; m_sat = 0;
      return;
    end
    c    = m_wb;
    s    = 1 - m_wb;
    fire = m_pend && (mq[s].size() == 0) && !v;
    if (ordy && mq[s].size() > 0) void'(mq[s].pop_front());
    if (v) begin
      if (code == C_INIT || code == C_ZERO) begin
        if (mq[c].size() < NB) mq[c].push_back(code == C_INIT ? p : '0);
        else m_ovf = 1;
      end else if (mq[c].size() == 0) begin
        m_udf = 1;
      end else begin
        h  = mq[c].pop_front();
        sm = longint'($signed(h)) + longint'($signed(p));
`ifdef ACCFIFO_SATURATE_EN
        if (code == C_ACC && sm > MAXV) begin
          sm = MAXV; m_sat = 1;
        end else if (code == C_ACC && sm < MINV) begin
          sm = MINV; m_sat = 1;
        end
`endif
        nv = (code == C_REC) ? h : W'(sm);
        mq[c].push_back(nv);
      end
    end
    m_ack = fire;
    if (fire) begin
      m_wb   = s;
      m_pend = sr;
    end else if (sr) begin
      m_pend = 1;
    end
  endtask

  task automatic compare_all();
    int s;
    s = 1 - m_wb;
    chk("compute_count", 32'(compute_count), 32'(mq[m_wb].size()));
    chk("shadow_count", 32'(shadow_count), 32'(mq[s].size()));
    chk("which_bank", 32'(which_bank), 32'(m_wb));
    chk("swap_ack", 32'(swap_ack), 32'(m_ack));
    chk("out_valid", 32'(out_valid), 32'(mq[s].size() > 0));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("udf_err", 32'(udf_err), 32'(m_udf));
    chk("sat_flag", 32'(sat_flag), 32'(m_sat));
    if (mq[s].size() > 0) chk("out_data", 32'(out_data), 32'(mq[s][0]));
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] code,
                      input logic [W-1:0] p, input logic sr, input logic ordy);
    rst = r; op_valid = v; op_code = code; psum_in = p; swap_req = sr; out_ready = ordy;
    model_step(r, v, code, p, sr, ordy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [W-1:0] exp_sat;
    logic [W-1:0] big;

    tbl[0]  = mk(1, C_INIT, 5, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, C_INIT, 7, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, C_INIT, 9, 0, 0, 3, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, C_ACC,  1, 0, 0, 3, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, C_ACC,  1, 0, 0, 3, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, C_ACC,  1, 0, 0, 3, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, C_INIT, 0, 1, 0, 3, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, C_INIT, 0, 0, 0, 0, 3, 1, 1, 1, 6);
    tbl[8]  = mk(0, C_INIT, 0, 0, 1, 0, 2, 1, 0, 1, 8);
    tbl[9]  = mk(0, C_INIT, 0, 0, 1, 0, 1, 1, 0, 1, 10);
    tbl[10] = mk(0, C_INIT, 0, 0, 1, 0, 0, 1, 0, 0, 0);

    rst = 1; op_valid = 0; op_code = 0; psum_in = 0; swap_req = 0; out_ready = 0;
    step(1, 0, C_INIT, 0, 0, 0);
    step(1, 0, C_INIT, 0, 0, 0);
    chk("rst_compute_count", 32'(compute_count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_which_bank", 32'(which_bank), 0);

    // Basic INIT/ACC/swap/drain flow from the table.
    for (int i = 0; i < 11; i++) begin
      step(0, tbl[i].v, tbl[i].code, tbl[i].p, tbl[i].sr, tbl[i].ordy);
      chk($sformatf("tbl%0d_cc", i), 32'(compute_count), 32'(tbl[i].cc));
      chk($sformatf("tbl%0d_sc", i), 32'(shadow_count), 32'(tbl[i].sc));
      chk($sformatf("tbl%0d_wb", i), 32'(which_bank), 32'(tbl[i].wb));
      chk($sformatf("tbl%0d_ack", i), 32'(swap_ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].data));
    end

    // Swap blocked while the shadow bank still holds data.
    step(0, 1, C_INIT, 3, 0, 0);
    step(0, 1, C_INIT, 4, 0, 0);
    step(0, 0, C_INIT, 0, 1, 0);
    step(0, 0, C_INIT, 0, 0, 0);
    chk("blk_first_swap_sc", 32'(shadow_count), 2);
    step(0, 0, C_INIT, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, C_INIT, 0, 0, 0);
      chk("blk_no_ack", 32'(swap_ack), 0);
    end
    step(0, 0, C_INIT, 0, 0, 1);
    step(0, 0, C_INIT, 0, 0, 1);
    chk("blk_ack_before_fire", 32'(swap_ack), 0);
    step(0, 0, C_INIT, 0, 0, 0);
    chk("blk_ack_after_fire", 32'(swap_ack), 1);
    chk("blk_wb_after_fire", 32'(which_bank), 1);

    // Full/empty boundaries.
    step(1, 0, C_INIT, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, C_INIT, W'(i), 0, 0);
    chk("bnd_ovf", 32'(ovf_err), 1);
    chk("bnd_full_cc", 32'(compute_count), 4);
    step(0, 1, C_ACC, 10, 0, 0);
    chk("bnd_acc_full_cc", 32'(compute_count), 4);
    step(0, 0, C_INIT, 0, 1, 0);
    step(0, 0, C_INIT, 0, 0, 0);
    step(0, 1, C_ACC, 1, 0, 0);
    chk("bnd_udf", 32'(udf_err), 1);
    chk("bnd_udf_cc", 32'(compute_count), 0);
    chk("bnd_head_after_acc", 32'(out_data), 2);
    for (int i = 0; i < 4; i++) step(0, 0, C_INIT, 0, 0, 1);
    chk("bnd_drained", 32'(out_valid), 0);

    // RECIRC keeps order; swap deferred while op_valid is held.
    step(1, 0, C_INIT, 0, 0, 0);
    for (int i = 1; i <= 3; i++) step(0, 1, C_INIT, W'(i), 0, 0);
    step(0, 1, C_REC, 0, 1, 0);
    chk("rec_defer_ack0", 32'(swap_ack), 0);
    step(0, 1, C_REC, 0, 0, 0);
    chk("rec_defer_ack1", 32'(swap_ack), 0);
    step(0, 1, C_REC, 0, 0, 0);
    chk("rec_defer_wb", 32'(which_bank), 0);
    chk("rec_cc", 32'(compute_count), 3);
    step(0, 0, C_INIT, 0, 0, 0);
    chk("rec_fire_wb", 32'(which_bank), 1);
    for (int i = 1; i <= 3; i++) begin
      chk("rec_order", 32'(out_data), 32'(i));
      step(0, 0, C_INIT, 0, 0, 1);
    end

    // Saturation boundary at the positive limit.
    step(1, 0, C_INIT, 0, 0, 0);
    step(0, 1, C_INIT, 24'h7FFFFF, 0, 0);
    step(0, 1, C_ACC, 1, 0, 0);
`ifdef ACCFIFO_SATURATE_EN
    exp_sat = 24'h7FFFFF;
    chk("sat_flag_set", 32'(sat_flag), 1);
`else
    exp_sat = 24'h800000;
    chk("sat_flag_tied", 32'(sat_flag), 0);
`endif
    step(0, 0, C_INIT, 0, 1, 0);
    step(0, 0, C_INIT, 0, 0, 0);
    chk("sat_value", 32'(out_data), 32'(exp_sat));

    // Reset in the middle of a drain.
    step(1, 0, C_INIT, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, C_INIT, W'(20 + i), 0, 0);
    step(0, 0, C_INIT, 0, 1, 0);
    step(0, 0, C_INIT, 0, 0, 1);
    step(0, 0, C_INIT, 0, 0, 1);
    step(1, 0, C_INIT, 0, 0, 1);
    chk("mid_rst_sc", 32'(shadow_count), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    step(0, 0, C_INIT, 0, 0, 1);
    chk("mid_rst_valid_next", 32'(out_valid), 0);
    chk("mid_rst_cc_next", 32'(compute_count), 0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      big = ($urandom_range(0, 5) == 0) ? 24'h7FFFF0 + W'($urandom_range(0, 31)) : W'($urandom());
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 9) < 6,
           2'($urandom_range(0, 3)),
           big,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pingpong_accfifo_v2.md
Name: pingpong_accfifo_v2

Overview:
- Next-generation double-buffered accumulation FIFO for the PE partial-sum path.
- Holds two FIFO banks in ping-pong: the compute bank takes accumulate/init/recirculate ops from the FoFIR adder side; the shadow bank drains finished sums to the global output chain over a valid/ready stream.
- Adds a swap handshake, an explicit opcode datapath, occupancy counts and sticky error flags.

Parameters:
- NB_DATA, 32, depth of each bank (power of two, >=2)
- DATA_WIDTH, 24, partial-sum width (two's complement)
- CNT_WIDTH, $clog2(NB_DATA+1), occupancy count width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- op_valid  in  1  compute op strobe
- op_code  in  2  0=INIT, 1=ACC, 2=ZERO, 3=RECIRC
- psum_in  in  DATA_WIDTH  FIR output partial sum
- swap_req  in  1  one-cycle request pulse to exchange bank roles
- swap_ack  out  1  one-cycle pulse, the cycle after the swap edge
- out_valid  out  1  shadow bank non-empty
- out_ready  in  1  downstream accepts out_data
- out_data  out  DATA_WIDTH  shadow head (first-word fall-through)
- compute_count  out  CNT_WIDTH  compute bank occupancy
- shadow_count  out  CNT_WIDTH  shadow bank occupancy
- which_bank  out  1  index of the current compute bank
- ovf_err  out  1  sticky: push dropped on full
- udf_err  out  1  sticky: pop requested on empty
- sat_flag  out  1  sticky: saturation occurred (tied 0 without macro)

Behaviour:
- Reset: pointers/counts 0, which_bank=0, swap_pending=0, swap_ack=0, all err flags 0; out_valid=0; RAM contents not cleared; reset mid-operation discards both banks' contents and any pending swap.
- Compute ops, effective at the rising edge when op_valid=1:
  - INIT: push psum_in.
  - ZERO: push 0.
  - ACC: pop head, push psum_in + head.
  - RECIRC: pop head, push head.
- Compute head is read combinationally (FWFT), so ACC/RECIRC have zero read latency; the written value is visible at the head after it wraps.
- Simultaneous pop+push on a full bank is legal; count is unchanged.
- Boundary conditions:
  - ACC/RECIRC on empty: no pop, no push, udf_err<=1.
  - INIT/ZERO on full: push dropped, ovf_err<=1.
- Arithmetic: ACC sum is DATA_WIDTH wide, modulo 2^DATA_WIDTH (see Optional Feature).
- Drain: out_valid = (shadow_count != 0). Pop at the edge when out_valid && out_ready. out_data is X-free only while out_valid=1. out_ready with empty shadow is a no-op, not an error.
- Swap:
  - swap_req sets swap_pending.
  - The swap fires at the first edge where swap_pending && shadow_count==0 && !op_valid. At that edge which_bank toggles and swap_pending clears; swap_ack=1 in the following cycle.
  - A swap_req while pending is absorbed, not counted twice.
  - A swap_req in the same cycle the swap fires starts a new pending request.
  - Drain pops in the firing cycle are impossible, since shadow is empty.
- Role exchange: counts follow the banks, so after a swap compute_count and shadow_count exchange values.
- Pointers wrap modulo NB_DATA.
- Err flags clear only on rst.

Optional Feature:
- Macro: ACCFIFO_SATURATE_EN.
- Defined: ACC computes a DATA_WIDTH+1 signed sum and clamps to [-2^(W-1), 2^(W-1)-1]; sat_flag<=1 on clamp.
- Undefined: wraparound add; sat_flag tied 0; no extra adder bit.

Decomposition:
- Package accfifo_pkg holds:
  - op_code enum (OP_INIT, OP_ACC, OP_ZERO, OP_RECIRC);
  - a function for saturating add;
  - localparam width helpers.
- One sub-module, accfifo_bank: a single-port-style FWFT sync FIFO with push/pop/count/empty/full, instantiated twice.
- Top handles op decode, bank muxing, swap FSM (IDLE/PENDING) and flags.

Test Plan:
- Reset then INIT psum 5,7,9 (3 ops) -> compute_count=3, out_valid=0, no err.
- Then 3× ACC with psum 1,1,1 -> bank holds 6,8,10; swap_req -> swap_ack one cycle after the swap edge, which_bank=1, shadow_count=3. Drain with out_ready=1 -> out_data 6,8,10 then out_valid=0.
- Swap blocked: shadow holds 2 entries, swap_req, out_ready=0 for 10 cycles -> no swap_ack. Raise out_ready -> swap fires on the edge after the second pop.
- Boundaries, NB_DATA=4:
  - 5× INIT -> ovf_err=1, count=4.
  - ACC on full -> count stays 4, head updated.
  - ACC on empty -> udf_err=1, count 0.
- RECRC order: INIT 1,2,3 then 3× RECIRC -> order preserved 1,2,3, count=3; op_valid held during swap_pending -> swap deferred until op_valid drops.
- With ACCFIFO_SATURATE_EN, W=24: INIT 0x7FFFFF then ACC psum 1 -> stored 0x7FFFFF, sat_flag=1. Without the macro -> 0x800000, sat_flag=0. rst asserted mid-drain -> counts 0, out_valid=0 next cycle.
